regfile_wr_arb: RTL and testbench
=================================

REGFILE_WR_ARB -- requirements
Module: regfile_wr_arb

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, depth of the multi-cycle-unit pending buffer (power of two, 2..8).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, the consecutive lost-arbitration cycles before the buffer head is forced.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports wb_valid  input  1, wb_reg  input  5, and wb_data  input  32, forming the pipeline writeback request.
REQ-006 SHALL have port wb_stall  output  1  pipeline writeback held; while it is 1 the producer holds wb_valid, wb_reg and wb_data stable.
REQ-007 SHALL have ports mc_valid  input  1, mc_reg  input  5, and mc_data  input  32, forming the multi-cycle-unit (mult/div) write request.
REQ-008 SHALL have port mc_ready  output  1  buffer can accept a request.
REQ-009 SHALL have ports rf_we  output  1, rf_reg  output  5, and rf_din  output  32, driving the register-file write port; the register file samples them on the following falling edge.
REQ-010 SHALL have port busy  output  1  buffer non-empty or a write is being issued.

Function
REQ-011 SHALL register rf_we/rf_reg/rf_din: a request granted at rising edge N appears on rf_* during cycle N+1.
REQ-012 SHALL accept an mc request when mc_valid=1 and mc_ready=1 at a rising edge, pushing {mc_reg, mc_data} into the FIFO.
REQ-013 SHALL drive mc_ready=1 iff occupancy<FIFO_DEPTH, based on current occupancy only; at full, a same-cycle pop does not enable a push.
REQ-014 SHALL grant per cycle by fixed priority: an unstalled wb_valid wins; otherwise a non-empty FIFO head is popped and issued; otherwise rf_we=0.
REQ-015 SHALL treat a granted request with reg=0 as consumed (popped/acknowledged) but SHALL drive rf_we=0 for it; $zero is never written.
REQ-016 SHALL keep the FSM states IDLE (FIFO empty), PEND (FIFO non-empty), and FORCE (one-cycle forced drain, REGFILE_ARB_STARVE_EN only).
REQ-017 SHALL make the transitions IDLE->PEND on push without pop, PEND->IDLE when the last entry pops with no push, PEND->FORCE when the starvation counter reaches STARVE_LIMIT, and FORCE->PEND or FORCE->IDLE after exactly one cycle according to occupancy.
REQ-018 SHALL increment the starvation counter (width clog2(STARVE_LIMIT+1)) each cycle in PEND in which the head is not granted, saturating at the limit, and SHALL clear it on any pop or on entering IDLE.
REQ-019 SHALL drive wb_stall=1 only in FORCE, where it is registered, so the head is issued that cycle and wb is granted the next cycle.
REQ-020 SHALL ignore wb_valid=0 in FORCE; FORCE still lasts exactly one cycle.
REQ-021 SHALL allow a same-cycle push and pop when the FIFO is not full, leaving occupancy unchanged, with read and write pointers wrapping modulo FIFO_DEPTH.
REQ-022 SHALL let an mc request pushed into an empty FIFO be granted no earlier than the next cycle; there is no bypass.
REQ-023 SHALL drive busy = (occupancy!=0) | rf_we.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously force state=IDLE, occupancy=0, pointers=0, starvation counter=0, rf_we=0, rf_reg=0, rf_din=0, and wb_stall=0; mc_ready=1 follows from occupancy=0.
REQ-025 SHALL discard FIFO contents when reset is asserted mid-operation; no write is issued after reset deasserts until a new grant occurs.

Configuration
REQ-026 SHALL, with REGFILE_ARB_STARVE_EN defined, implement the starvation counter, the FORCE state and the registered wb_stall.
REQ-027 SHALL, without REGFILE_ARB_STARVE_EN, tie wb_stall to 0 and omit the counter and FORCE, so mc can starve indefinitely under continuous wb traffic.

Structure
REQ-028 SHALL place the FSM state enum (IDLE/PEND/FORCE) and the width constants (REG_ADDR_W=5, DATA_W=32) in the shared package regfile_pkg.
REQ-029 SHALL implement the pending buffer as sub-module regfile_wr_fifo, carrying push/pop/full/empty and a head-data output, and SHALL keep the arbitration/FSM in regfile_wr_arb.

Verification
REQ-030 SHALL verify wb only: wb_valid=1, wb_reg=8, wb_data=0x1234 -> next cycle rf_we=1, rf_reg=8, rf_din=0x1234; mc_ready stays 1.
REQ-031 SHALL verify $zero suppression: wb_reg=0, wb_data=0xFFFF -> rf_we stays 0 and the request is not retried.
REQ-032 SHALL verify full FIFO: 2 mc pushes with wb_valid held 1 -> mc_ready=0; a third mc_valid is not accepted; after wb drops, entries issue in order on 2 consecutive cycles.
REQ-033 SHALL verify starvation with the macro defined: 1 mc entry and continuous wb_valid -> after 4 lost cycles, wb_stall=1 for one cycle, the mc entry is written, then the held wb write issues next cycle.
REQ-034 SHALL verify no starvation guard without the macro: the same stimulus -> wb_stall never 1 and the mc entry is never issued while wb_valid=1.
REQ-035 SHALL verify reset mid-drain: rst_n=0 with 2 entries queued -> rf_we=0 immediately, mc_ready=1, busy=0, and no stale write after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Holds the arbiter FSM state encoding, the write-request record carried
// through the pending buffer, and a small helper that screens out $zero.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wr_req_t;

  // Register 0 is hard-wired to zero, so a request aimed at it is consumed
  // without producing a write strobe.
  function automatic logic reg_writable(input logic [REG_ADDR_W-1:0] addr);
    return (addr != {REG_ADDR_W{1'b0}});
  endfunction

endpackage

// File: rtl/regfile_wr_arb_if.sv
// Bundle of the writeback, multi-cycle-unit and register-file write signals
// seen by the write arbiter. The "master" side is the surrounding pipeline
// (producers and register file); the "slave" side is the arbiter itself.
interface regfile_wr_arb_if;
  import regfile_pkg::*;

  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_reg;
  logic [DATA_W-1:0]     wb_data;
  logic                  wb_stall;

  logic                  mc_valid;
  logic [REG_ADDR_W-1:0] mc_reg;
  logic [DATA_W-1:0]     mc_data;
  logic                  mc_ready;

  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_reg;
  logic [DATA_W-1:0]     rf_din;
  logic                  busy;

  modport master (
    output wb_valid, wb_reg, wb_data,
    input  wb_stall,
    output mc_valid, mc_reg, mc_data,
    input  mc_ready,
    input  rf_we, rf_reg, rf_din, busy
  );

  modport slave (
    input  wb_valid, wb_reg, wb_data,
    output wb_stall,
    input  mc_valid, mc_reg, mc_data,
    output mc_ready,
    output rf_we, rf_reg, rf_din, busy
  );

endinterface

// File: rtl/regfile_wr_fifo.sv
// Pending buffer for multi-cycle-unit register writes.
// Circular buffer of DEPTH entries (power of two) with an occupancy counter.
// Push is ignored when full and pop is ignored when empty; a simultaneous
// push and pop leaves the occupancy unchanged. The head entry is presented
// combinationally from storage.
module regfile_wr_fifo
  import regfile_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  wr_req_t          push_req,
  input  logic             pop,
  output wr_req_t          head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  wr_req_t          mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             full_s;
  logic             empty_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_s    = (count_r == CNT_W'(DEPTH));
  assign empty_s   = (count_r == {CNT_W{1'b0}});
  assign push_ok_s = push & ~full_s;
  assign pop_ok_s  = pop & ~empty_s;

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Entry storage; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_req;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2**PTR_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_nxt_s;
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign full  = full_s;
  assign empty = empty_s;
  assign count = count_r;

endmodule

// File: rtl/regfile_wr_arb.sv
// Register-file write-port arbiter.
// Merges the pipeline writeback stream with buffered multi-cycle-unit
// results onto a single registered register-file write port. Writeback has
// fixed priority; buffered entries drain whenever writeback is idle.
// Optional feature macro REGFILE_ARB_STARVE_EN: adds a starvation counter
// that, after STARVE_LIMIT consecutive lost cycles, stalls writeback for one
// cycle (FORCE state) so the buffer head is written. Without the macro the
// stall output is tied low and buffered entries wait for a writeback gap.
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst_n,
  regfile_wr_arb_if.slave  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 8) ||
      ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (STARVE_LIMIT < 1)) begin : g_bad_cfg
    $error("regfile_wr_arb: FIFO_DEPTH must be a power of two in 2..8 and STARVE_LIMIT >= 1");
  end

  arb_state_e            state_r;
  arb_state_e            state_nxt_s;
  wr_req_t               mc_req_s;
  wr_req_t               head_s;
  wr_req_t               grant_req_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  grant_s;
  logic                  full_s;
  logic                  empty_s;
  logic [CNT_W-1:0]      count_s;
  logic                  last_pop_s;
  logic                  wb_stall_s;
  logic                  starve_hit_s;
  logic                  rf_we_r;
  logic [REG_ADDR_W-1:0] rf_reg_r;
  logic [DATA_W-1:0]     rf_din_r;

  // Acceptance depends on current occupancy only: a pop in the same cycle
  // does not free a slot for a push when the buffer is full.
  assign push_s        = bus.mc_valid & ~full_s;
  assign mc_req_s.addr = bus.mc_reg;
  assign mc_req_s.data = bus.mc_data;

  // The buffer drains to empty when its only entry leaves and nothing arrives.
  assign last_pop_s = pop_s & ~push_s & (count_s == CNT_W'(1));

  regfile_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_s),
    .push_req (mc_req_s),
    .pop      (pop_s),
    .head     (head_s),
    .full     (full_s),
    .empty    (empty_s),
    .count    (count_s)
  );

  // Fixed-priority grant: unstalled writeback, else buffer head, else nothing.
  always_comb begin
    pop_s            = 1'b0;
    grant_s          = 1'b0;
    grant_req_s.addr = {REG_ADDR_W{1'b0}};
    grant_req_s.data = {DATA_W{1'b0}};
    if (bus.wb_valid && !wb_stall_s) begin
      grant_s          = 1'b1;
      grant_req_s.addr = bus.wb_reg;
      grant_req_s.data = bus.wb_data;
    end else if (!empty_s) begin
      pop_s       = 1'b1;
      grant_s     = 1'b1;
      grant_req_s = head_s;
    end else begin
      grant_s = 1'b0;
    end
  end

`ifdef REGFILE_ARB_STARVE_EN
  localparam int               STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] LIMIT_C = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_r;
  logic [STARVE_W-1:0] starve_nxt_s;
  logic                starve_inc_s;
  logic                wb_stall_r;

  // A lost cycle is a PEND cycle in which the head was not popped.
  assign starve_inc_s = (state_r == PEND) & ~pop_s;

  // Saturating count of consecutive lost cycles; any pop restarts it.
  always_comb begin
    starve_nxt_s = starve_r;
    if (pop_s) begin
      starve_nxt_s = {STARVE_W{1'b0}};
    end else if (starve_inc_s && (starve_r != LIMIT_C)) begin
      starve_nxt_s = starve_r + STARVE_W'(1);
    end else begin
      starve_nxt_s = starve_r;
    end
  end

  assign starve_hit_s = starve_inc_s & (starve_nxt_s == LIMIT_C);

  // Starvation counter and the registered writeback stall that marks FORCE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_r   <= {STARVE_W{1'b0}};
      wb_stall_r <= 1'b0;
    end else begin
      starve_r   <= starve_nxt_s;
      wb_stall_r <= (state_nxt_s == FORCE);
    end
  end

  assign wb_stall_s = wb_stall_r;
`else
  assign starve_hit_s = 1'b0;
  assign wb_stall_s   = 1'b0;
`endif

  // FSM next state: IDLE/PEND track buffer occupancy, FORCE lasts one cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (push_s) begin
          state_nxt_s = PEND;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PEND: begin
        if (last_pop_s) begin
          state_nxt_s = IDLE;
        end else if (starve_hit_s) begin
          state_nxt_s = FORCE;
        end else begin
          state_nxt_s = PEND;
        end
      end
      FORCE: begin
        if (last_pop_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = PEND;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered write port; a granted $zero request clears the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_r  <= 1'b0;
      rf_reg_r <= {REG_ADDR_W{1'b0}};
      rf_din_r <= {DATA_W{1'b0}};
    end else if (grant_s) begin
      rf_we_r  <= reg_writable(grant_req_s.addr);
      rf_reg_r <= grant_req_s.addr;
      rf_din_r <= grant_req_s.data;
    end else begin
      rf_we_r  <= 1'b0;
    end
  end

  assign bus.wb_stall = wb_stall_s;
  assign bus.mc_ready = ~full_s;
  assign bus.rf_we    = rf_we_r;
  assign bus.rf_reg   = rf_reg_r;
  assign bus.rf_din   = rf_din_r;
  assign bus.busy     = (count_s != {CNT_W{1'b0}}) | rf_we_r;

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Self-checking bench for regfile_wr_arb (FIFO_DEPTH=2, STARVE_LIMIT=4).
// Expected register-file writes are queued as stimulus is driven and are
// compared in order whenever the DUT raises rf_we. Starvation behaviour is
// exercised in whichever form REGFILE_ARB_STARVE_EN selects.
module tb_regfile_wr_arb;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  wr_req_t exp_q[$];
  wr_req_t mon_e;

  always #5 clk = ~clk;

  regfile_wr_arb_if bus();

  regfile_wr_arb #(
    .FIFO_DEPTH   (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    checks++;
    if (obs !== req) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] addr, input logic [31:0] data);
    wr_req_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_we", 64'(bus.rf_we), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_reg", 64'(bus.rf_reg), 64'(mon_e.addr));
        chk("sb_data", 64'(bus.rf_din), 64'(mon_e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    bus.wb_valid = 1'b0;
    bus.wb_reg   = 5'd0;
    bus.wb_data  = 32'd0;
    bus.mc_valid = 1'b0;
    bus.mc_reg   = 5'd0;
    bus.mc_data  = 32'd0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf_we", 64'(bus.rf_we), 64'd0);
    chk("rst_rf_reg", 64'(bus.rf_reg), 64'd0);
    chk("rst_rf_din", 64'(bus.rf_din), 64'd0);
    chk("rst_mc_ready", 64'(bus.mc_ready), 64'd1);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_wb_stall", 64'(bus.wb_stall), 64'd0);
    rst_n = 1'b1;
    tick();

    // Writeback only.
    bus.wb_valid = 1'b1;
    bus.wb_reg   = 5'd8;
    bus.wb_data  = 32'h0000_1234;
    expect_wr(5'd8, 32'h0000_1234);
    tick();
    bus.wb_valid = 1'b0;
    chk("wb_rf_we", 64'(bus.rf_we), 64'd1);
    chk("wb_mc_ready", 64'(bus.mc_ready), 64'd1);
    chk("wb_busy", 64'(bus.busy), 64'd1);
    tick();
    chk("wb_done_we", 64'(bus.rf_we), 64'd0);

    // $zero suppression, no retry.
    bus.wb_valid = 1'b1;
    bus.wb_reg   = 5'd0;
    bus.wb_data  = 32'h0000_FFFF;
    tick();
    bus.wb_valid = 1'b0;
    chk("zero_we_0", 64'(bus.rf_we), 64'd0);
    tick();
    chk("zero_we_1", 64'(bus.rf_we), 64'd0);
    chk("zero_busy", 64'(bus.busy), 64'd0);

    // Full buffer: writeback held (to $zero, so it writes nothing).
    bus.wb_valid = 1'b1;
    bus.wb_reg   = 5'd0;
    bus.mc_valid = 1'b1;
    bus.mc_reg   = 5'd10;
    bus.mc_data  = 32'hAAAA_0001;
    tick();
    chk("full_ready_1", 64'(bus.mc_ready), 64'd1);
    bus.mc_reg  = 5'd11;
    bus.mc_data = 32'hAAAA_0002;
    tick();
    chk("full_ready_2", 64'(bus.mc_ready), 64'd0);
    chk("full_busy", 64'(bus.busy), 64'd1);
    bus.mc_reg  = 5'd12;
    bus.mc_data = 32'h0000_0BAD;
    tick();
    chk("full_reject", 64'(bus.mc_ready), 64'd0);
    bus.mc_valid = 1'b0;
    bus.wb_valid = 1'b0;
    expect_wr(5'd10, 32'hAAAA_0001);
    expect_wr(5'd11, 32'hAAAA_0002);
    tick();
    chk("drain_we_1", 64'(bus.rf_we), 64'd1);
    chk("drain_reg_1", 64'(bus.rf_reg), 64'd10);
    chk("drain_ready", 64'(bus.mc_ready), 64'd1);
    tick();
    chk("drain_we_2", 64'(bus.rf_we), 64'd1);
    chk("drain_reg_2", 64'(bus.rf_reg), 64'd11);
    tick();
    chk("drain_idle_we", 64'(bus.rf_we), 64'd0);
    chk("drain_idle_busy", 64'(bus.busy), 64'd0);

    // Starvation: one mc entry against continuous writeback.
    bus.wb_valid = 1'b1;
    bus.wb_reg   = 5'd5;
    bus.mc_valid = 1'b1;
    bus.mc_reg   = 5'd20;
    bus.mc_data  = 32'hC0DE_0020;
`ifdef REGFILE_ARB_STARVE_EN
    for (int i = 1; i <= 5; i++) begin
      bus.wb_data = 32'h5500_0000 + 32'(i);
      expect_wr(5'd5, 32'h5500_0000 + 32'(i));
      tick();
      bus.mc_valid = 1'b0;
      chk($sformatf("starve_stall_%0d", i), 64'(bus.wb_stall), (i == 5) ? 64'd1 : 64'd0);
    end
    bus.wb_data = 32'h5500_0006;
    expect_wr(5'd20, 32'hC0DE_0020);
    expect_wr(5'd5, 32'h5500_0006);
    tick();
    chk("force_stall_off", 64'(bus.wb_stall), 64'd0);
    chk("force_reg", 64'(bus.rf_reg), 64'd20);
    tick();
    chk("force_wb_reg", 64'(bus.rf_reg), 64'd5);
    chk("force_wb_din", 64'(bus.rf_din), 64'h5500_0006);
    bus.wb_valid = 1'b0;
    tick();
`else
    for (int i = 1; i <= 8; i++) begin
      bus.wb_data = 32'h5500_0000 + 32'(i);
      expect_wr(5'd5, 32'h5500_0000 + 32'(i));
      tick();
      bus.mc_valid = 1'b0;
      chk($sformatf("nostarve_stall_%0d", i), 64'(bus.wb_stall), 64'd0);
      chk($sformatf("nostarve_busy_%0d", i), 64'(bus.busy), 64'd1);
    end
    expect_wr(5'd20, 32'hC0DE_0020);
    bus.wb_valid = 1'b0;
    tick();
    chk("nostarve_mc_reg", 64'(bus.rf_reg), 64'd20);
    tick();
`endif
    chk("starve_end_we", 64'(bus.rf_we), 64'd0);
    chk("starve_end_busy", 64'(bus.busy), 64'd0);

    // Reset mid-drain with two entries queued and a write on the port.
    bus.wb_valid = 1'b1;
    bus.wb_reg   = 5'd7;
    bus.wb_data  = 32'h0000_0070;
    bus.mc_valid = 1'b1;
    bus.mc_reg   = 5'd30;
    bus.mc_data  = 32'h0000_0030;
    expect_wr(5'd7, 32'h0000_0070);
    tick();
    bus.mc_reg   = 5'd31;
    bus.mc_data  = 32'h0000_0031;
    bus.wb_data  = 32'h0000_0071;
    expect_wr(5'd7, 32'h0000_0071);
    tick();
    bus.mc_valid = 1'b0;
    chk("pre_rst_ready", 64'(bus.mc_ready), 64'd0);
    @(negedge clk);
    #1;
    bus.wb_valid = 1'b0;
    rst_n        = 1'b0;
    #1;
    chk("mid_rst_we", 64'(bus.rf_we), 64'd0);
    chk("mid_rst_ready", 64'(bus.mc_ready), 64'd1);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_reg", 64'(bus.rf_reg), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post_rst_we_%0d", i), 64'(bus.rf_we), 64'd0);
      chk($sformatf("post_rst_busy_%0d", i), 64'(bus.busy), 64'd0);
    end

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
